// File: rtl/player_shot_ctrl.sv
// player_shot_ctrl
//   Schedules player shots over a shared pool of NUM_SLOTS bullet slots. A movement
//   tick is derived from the clock; on each tick a fire FSM (READY/COOL) may
//   allocate the lowest free slot at the player's muzzle, and every slot that was
//   active before the tick moves up by SPEED pixels or retires at the top edge.
//   Hits reported by collision logic free a slot at the next edge.
//
//   Optional feature macro: DUAL_SHOT_EN. When it is defined, each shot takes the
//   two lowest free slots, at player_x-8 and player_x+8.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_ctrl_fire    fire button level
//   i_player_x     player centre x
//   i_player_y     player centre y
//   i_hit_valid    one-cycle pulse: slot i_hit_slot collided
//   i_hit_slot     index of the hit slot
//   o_slot_active  per-slot active flag
//   o_slot_x       slot i x at [10*i+9:10*i]
//   o_slot_y       slot i y at [10*i+9:10*i]
//   o_shot_fired   one-cycle pulse on each allocation
//   o_pool_full    all slots active (combinational)

module player_shot_ctrl #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned TICK_DIV   = 2000000,
  parameter int unsigned COOLDOWN   = 8,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned MUZZLE_OFS = 24
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_ctrl_fire,
  input  logic [9:0]                   i_player_x,
  input  logic [9:0]                   i_player_y,
  input  logic                         i_hit_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_hit_slot,
  output logic [NUM_SLOTS-1:0]         o_slot_active,
  output logic [10*NUM_SLOTS-1:0]      o_slot_x,
  output logic [10*NUM_SLOTS-1:0]      o_slot_y,
  output logic                         o_shot_fired,
  output logic                         o_pool_full
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(COOLDOWN + 1);

  localparam logic [CW-1:0] TickLast = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] CoolInit = DW'(COOLDOWN);
  localparam logic [9:0]    Speed10  = 10'(SPEED);
  localparam logic [9:0]    Muzzle10 = 10'(MUZZLE_OFS);
  localparam logic [9:0]    DualOfs  = 10'd8;

  typedef enum logic [0:0] {StReady, StCool} state_e;

  state_e               r_state;
  logic [CW-1:0]        r_tick_cnt;
  logic [DW-1:0]        r_cool;
  logic [NUM_SLOTS-1:0] r_slot_active;
  logic [9:0]           r_slot_x [NUM_SLOTS];
  logic [9:0]           r_slot_y [NUM_SLOTS];
  logic                 r_shot_fired;

  logic                 w_tick;
  logic [NUM_SLOTS-1:0] w_sel_lo;
  logic [NUM_SLOTS-1:0] w_sel_hi;
  logic                 w_lo_found;
  logic                 w_hi_found;
  logic                 w_muzzle_ok;
  logic                 w_can_shoot;
  logic                 w_fire;
  logic [9:0]           w_shot_y;
  logic [9:0]           w_x_lo;
  logic [9:0]           w_x_hi;

  assign w_tick = (r_tick_cnt == TickLast);

  // One-hot selects for the lowest and second-lowest free slot, taken from the
  // active mask before this edge so slots freed this edge are not reused yet.
  always_comb begin
    w_sel_lo   = '0;
    w_sel_hi   = '0;
    w_lo_found = 1'b0;
    w_hi_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!r_slot_active[i]) begin
        if (!w_lo_found) begin
          w_lo_found  = 1'b1;
          w_sel_lo[i] = 1'b1;
        end else if (!w_hi_found) begin
          w_hi_found  = 1'b1;
          w_sel_hi[i] = 1'b1;
        end
      end
    end
  end

  assign w_muzzle_ok = (i_player_y >= Muzzle10);
  assign w_shot_y    = i_player_y - Muzzle10;

`ifdef DUAL_SHOT_EN
  assign w_can_shoot = w_lo_found && w_hi_found && w_muzzle_ok && (i_player_x >= DualOfs);
  assign w_x_lo      = i_player_x - DualOfs;
  assign w_x_hi      = i_player_x + DualOfs;
`else
  assign w_can_shoot = w_lo_found && w_muzzle_ok;
  assign w_x_lo      = i_player_x;
  assign w_x_hi      = i_player_x;
`endif

  assign w_fire = w_tick && (r_state == StReady) && i_ctrl_fire && w_can_shoot;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StReady;
      r_tick_cnt    <= '0;
      r_cool        <= '0;
      r_slot_active <= '0;
      r_shot_fired  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slot_x[i] <= '0;
        r_slot_y[i] <= '0;
      end
    end else begin
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + CW'(1);
      r_shot_fired <= w_fire;

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_fire && w_sel_lo[i]) begin
          r_slot_active[i] <= 1'b1;
          r_slot_x[i]      <= w_x_lo;
          r_slot_y[i]      <= w_shot_y;
`ifdef DUAL_SHOT_EN
        end else if (w_fire && w_sel_hi[i]) begin
          r_slot_active[i] <= 1'b1;
          r_slot_x[i]      <= w_x_hi;
          r_slot_y[i]      <= w_shot_y;
`endif
        end else if (i_hit_valid && (int'(i_hit_slot) == i)) begin
          // Hit beats movement; coordinates hold so the renderer sees no jump.
          r_slot_active[i] <= 1'b0;
        end else if (w_tick && r_slot_active[i]) begin
          if (r_slot_y[i] >= Speed10) begin
            r_slot_y[i] <= r_slot_y[i] - Speed10;
          end else begin
            r_slot_active[i] <= 1'b0;
          end
        end
      end

      unique case (r_state)
        StReady: begin
          if (w_fire) begin
            r_cool  <= CoolInit;
            r_state <= StCool;
          end
        end
        StCool: begin
          if (w_tick) begin
            r_cool <= r_cool - DW'(1);
            if (r_cool == DW'(1)) begin
              r_state <= StReady;
            end
          end
        end
        default: r_state <= StReady;
      endcase
    end
  end

  always_comb begin
    o_slot_x = '0;
    o_slot_y = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      o_slot_x[10*i +: 10] = r_slot_x[i];
      o_slot_y[10*i +: 10] = r_slot_y[i];
    end
  end

  assign o_slot_active = r_slot_active;
  assign o_shot_fired  = r_shot_fired;
  assign o_pool_full   = &r_slot_active;

  // w_x_hi / w_sel_hi only feed the dual-shot path; keep them observed otherwise.
  logic w_unused;
  assign w_unused = ^{w_x_hi, w_sel_hi};

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Self-checking bench for player_shot_ctrl (TICK_DIV=4, COOLDOWN=2, SPEED=4,
// NUM_SLOTS=4). A behavioural model pushes the expected outputs for every cycle
// into a queue as inputs are applied; each is popped and compared after the edge.
// Directed scenarios add fixed-value checks at key points.

module tb_player_shot_ctrl;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fire;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        hit_valid;
  logic [1:0]  hit_slot;
  logic [NS-1:0]    o_slot_active;
  logic [10*NS-1:0] o_slot_x;
  logic [10*NS-1:0] o_slot_y;
  logic             o_shot_fired;
  logic             o_pool_full;

  always #5 clk = ~clk;

  player_shot_ctrl #(
    .NUM_SLOTS (NS),
    .TICK_DIV  (4),
    .COOLDOWN  (2),
    .SPEED     (4),
    .MUZZLE_OFS(24)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_ctrl_fire  (fire),
    .i_player_x   (px),
    .i_player_y   (py),
    .i_hit_valid  (hit_valid),
    .i_hit_slot   (hit_slot),
    .o_slot_active(o_slot_active),
    .o_slot_x     (o_slot_x),
    .o_slot_y     (o_slot_y),
    .o_shot_fired (o_shot_fired),
    .o_pool_full  (o_pool_full)
  );

  typedef struct packed {
    logic [NS-1:0]    act;
    logic [10*NS-1:0] x;
    logic [10*NS-1:0] y;
    logic             fired;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int      m_cnt;
  bit      m_cool;
  int      m_cd;
  bit [3:0] m_act;
  int      m_x[NS];
  int      m_y[NS];
  bit      m_fired;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    exp_t     e;
    bit       tick;
    bit [3:0] prev;
    int       j;
    int       k;
    if (reset) begin
      m_cnt = 0; m_cool = 0; m_cd = 0; m_act = '0; m_fired = 0;
      for (int i = 0; i < NS; i++) begin
        m_x[i] = 0;
        m_y[i] = 0;
      end
    end else begin
      tick    = (m_cnt == 3);
      m_cnt   = tick ? 0 : m_cnt + 1;
      prev    = m_act;
      m_fired = 0;
      if (tick) begin
        for (int i = 0; i < NS; i++) begin
          if (prev[i] && !(hit_valid && int'(hit_slot) == i)) begin
            if (m_y[i] >= 4) m_y[i] = m_y[i] - 4;
            else m_act[i] = 1'b0;
          end
        end
      end
      if (hit_valid) m_act[hit_slot] = 1'b0;
      if (tick) begin
        if (m_cool) begin
          m_cd = m_cd - 1;
          if (m_cd == 0) m_cool = 0;
        end else if (fire && py >= 24) begin
          j = -1;
          k = -1;
          for (int i = 0; i < NS; i++) begin
            if (!prev[i]) begin
              if (j < 0) j = i;
              else if (k < 0) k = i;
            end
          end
`ifdef DUAL_SHOT_EN
          if (k >= 0 && px >= 8) begin
            m_act[j] = 1'b1; m_x[j] = int'(px) - 8; m_y[j] = int'(py) - 24;
            m_act[k] = 1'b1; m_x[k] = int'(px) + 8; m_y[k] = int'(py) - 24;
            m_fired = 1;
          end
`else
          if (j >= 0) begin
            m_act[j] = 1'b1; m_x[j] = int'(px); m_y[j] = int'(py) - 24;
            m_fired = 1;
          end
`endif
          if (m_fired) begin
            m_cd   = 2;
            m_cool = 1;
          end
        end
      end
    end
    e.act   = m_act;
    e.fired = m_fired;
    e.x     = '0;
    e.y     = '0;
    for (int i = 0; i < NS; i++) begin
      e.x[10*i +: 10] = 10'(m_x[i]);
      e.y[10*i +: 10] = 10'(m_y[i]);
    end
    q.push_back(e);
  endtask

  // Apply current inputs for one clock and compare against the model.
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_eq("sb_active", o_slot_active, e.act);
    check_eq("sb_x", o_slot_x, e.x);
    check_eq("sb_y", o_slot_y, e.y);
    check_eq("sb_fired", o_shot_fired, e.fired);
    check_eq("sb_pool_full", o_pool_full, &e.act);
  endtask

  task automatic wait_shot(input int max, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!o_shot_fired && n < max);
    check_eq("shot_seen", o_shot_fired, 1);
  endtask

  task automatic run(input int cycles, output int shots);
    shots = 0;
    for (int i = 0; i < cycles; i++) begin
      cycle();
      if (o_shot_fired) shots++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int shots;
    reset = 1'b1; fire = 1'b0; px = 10'd0; py = 10'd0;
    hit_valid = 1'b0; hit_slot = 2'd0;
    cycle();
    cycle();
    check_eq("rst_active", o_slot_active, 0);
    check_eq("rst_x", o_slot_x, 0);
    check_eq("rst_y", o_slot_y, 0);
    check_eq("rst_fired", o_shot_fired, 0);
    reset = 1'b0;

`ifdef DUAL_SHOT_EN
    // Dual shot: two slots per shot, then one free slot is not enough.
    px = 10'd192; py = 10'd400; fire = 1'b1;
    wait_shot(10, n);
    check_eq("dual_x0", o_slot_x[9:0], 184);
    check_eq("dual_x1", o_slot_x[19:10], 200);
    check_eq("dual_y0", o_slot_y[9:0], 376);
    check_eq("dual_y1", o_slot_y[19:10], 376);
    check_eq("dual_act", o_slot_active, 4'b0011);
    wait_shot(20, n);
    check_eq("dual_full", o_slot_active, 4'b1111);
    hit_valid = 1'b1; hit_slot = 2'd3;
    cycle();
    hit_valid = 1'b0;
    run(20, shots);
    check_eq("dual_one_free_noshot", shots, 0);
`else
    // 1: first shot and cooldown spacing
    px = 10'd192; py = 10'd400; fire = 1'b1;
    wait_shot(10, n);
    check_eq("first_shot_lat", n, 4);
    check_eq("s1_x0", o_slot_x[9:0], 192);
    check_eq("s1_y0", o_slot_y[9:0], 376);
    check_eq("s1_act", o_slot_active, 4'b0001);
    cycle();
    check_eq("s1_fired_pulse", o_shot_fired, 0);
    wait_shot(20, n);
    check_eq("s1_spacing", n, 11);
    check_eq("s1_act2", o_slot_active, 4'b0011);
    check_eq("s1_y1", o_slot_y[19:10], 376);
    check_eq("s1_y0_moved", o_slot_y[9:0], 364);

    // 2: fill the pool, hold while full, free slot2 by a hit
    n = 0;
    while (!o_pool_full && n < 40) begin
      cycle();
      n++;
    end
    check_eq("s2_pool_full", o_pool_full, 1);
    run(16, shots);
    check_eq("s2_no_shot_full", shots, 0);
    hit_valid = 1'b1; hit_slot = 2'd2;
    cycle();
    hit_valid = 1'b0;
    check_eq("s2_hit_cleared", o_slot_active, 4'b1011);
    wait_shot(8, n);
    check_eq("s2_realloc_lat", n, 3);
    check_eq("s2_realloc_act", o_slot_active, 4'b1111);
    check_eq("s2_realloc_y2", o_slot_y[29:20], 376);

    // 3: top-edge retirement without wrap
    do_reset();
    px = 10'd100; py = 10'd30; fire = 1'b1;
    wait_shot(10, n);
    fire = 1'b0;
    check_eq("s3_y6", o_slot_y[9:0], 6);
    run(4, shots);
    check_eq("s3_y2", o_slot_y[9:0], 2);
    check_eq("s3_alive", o_slot_active, 4'b0001);
    run(4, shots);
    check_eq("s3_retired", o_slot_active, 4'b0000);
    check_eq("s3_no_wrap", o_slot_y[9:0], 2);

    // 4: player too close to the top edge
    do_reset();
    px = 10'd192; py = 10'd20; fire = 1'b1;
    run(20, shots);
    check_eq("s4_no_shot", shots, 0);
    check_eq("s4_none_active", o_slot_active, 0);
    py = 10'd400;
    wait_shot(4, n);

    // 5: hit on a tick edge beats movement; hit on inactive slot ignored
    do_reset();
    px = 10'd192; py = 10'd400; fire = 1'b1;
    wait_shot(10, n);
    wait_shot(20, n);
    fire = 1'b0;
    run(3, shots);
    hit_valid = 1'b1; hit_slot = 2'd1;
    cycle();
    hit_valid = 1'b0;
    check_eq("s5_hit_act", o_slot_active, 4'b0001);
    check_eq("s5_hit_y1_held", o_slot_y[19:10], 376);
    check_eq("s5_y0_moved", o_slot_y[9:0], 360);
    hit_valid = 1'b1; hit_slot = 2'd3;
    cycle();
    hit_valid = 1'b0;
    check_eq("s5_inactive_hit", o_slot_active, 4'b0001);

    // 6: reset mid-cooldown
    do_reset();
    fire = 1'b1;
    wait_shot(10, n);
    wait_shot(20, n);
    wait_shot(20, n);
    check_eq("s6_three", o_slot_active, 4'b0111);
    reset = 1'b1;
    cycle();
    check_eq("s6_rst_act", o_slot_active, 0);
    check_eq("s6_rst_x", o_slot_x, 0);
    check_eq("s6_rst_y", o_slot_y, 0);
    check_eq("s6_rst_fired", o_shot_fired, 0);
    reset = 1'b0;
    wait_shot(10, n);
    check_eq("s6_first_shot_lat", n, 4);
`endif

    check_eq("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
